round_scorekeeper: RTL and testbench



---
 rtl/round_scorekeeper_pkg.sv | 22 ++
 rtl/round_scorekeeper_cycle_timer.sv | 27 ++
 rtl/round_scorekeeper.sv | 147 ++++++++++++++
 tb/tb_round_scorekeeper.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/round_scorekeeper_pkg.sv
// Shared game definitions: scorekeeper state encoding and default timing
// that the arbiter top also uses.
package round_scorekeeper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_HOLD  = 3'd2,
        ST_CLEAR = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int DEF_SCORE_W     = 4;
    localparam int DEF_WIN_SCORE   = 5;
    localparam int DEF_HOLD_CYCLES = 25000000;
    localparam int DEF_CLR_CYCLES  = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/round_scorekeeper_cycle_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// Loading N-1 therefore gives a phase of exactly N cycles.
module round_scorekeeper_cycle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/round_scorekeeper.sv
// Consumer of the reaction arbiter's result: arms it, scores each round,
// shows the result on lamps for a while, then clears for the next round.
//
// state | meaning
// IDLE  | after reset, arbiter disarmed, waiting for new_match
// ARMED | arbiter armed, waiting for winrnd
// HOLD  | result displayed on lamps, arbiter holds its result
// CLEAR | clr pulse to the arbiter before re-arming
// DONE  | match won, scores frozen until new_match
module round_scorekeeper
    import round_scorekeeper_pkg::*;
#(
    parameter int SCORE_W     = DEF_SCORE_W,
    parameter int WIN_SCORE   = DEF_WIN_SCORE,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int CLR_CYCLES  = DEF_CLR_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               new_match,
    input  logic               winrnd,
    input  logic               right,
    input  logic               tie,
    output logic               clr,
    output logic               lamp_l,
    output logic               lamp_r,
    output logic               lamp_tie,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic [SCORE_W-1:0] ties,
    output logic               match_done,
    output logic               winner_r
);

    localparam int TW = $clog2(max_int(HOLD_CYCLES, CLR_CYCLES) + 1);
    localparam logic [TW-1:0]      HOLD_LD = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0]      CLR_LD  = TW'(CLR_CYCLES - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

    state_t          state;
    logic            t_load;
    logic [TW-1:0]   t_val;
    logic            t_done;
    logic            win_reached;

    assign win_reached = (score_l == WIN_VAL) || (score_r == WIN_VAL);

    // The timer is reloaded on the same edge the FSM enters HOLD or CLEAR.
    always_comb begin
        t_load = 1'b0;
        t_val  = '0;
        if (new_match) begin
            t_load = 1'b1;
            t_val  = CLR_LD;
        end else if (state == ST_ARMED && winrnd) begin
            t_load = 1'b1;
            t_val  = HOLD_LD;
        end else if (state == ST_HOLD && t_done && !win_reached) begin
            t_load = 1'b1;
            t_val  = CLR_LD;
        end
    end

    round_scorekeeper_cycle_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (t_load),
        .load_val (t_val),
        .done     (t_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            clr        <= 1'b1;
            lamp_l     <= 1'b0;
            lamp_r     <= 1'b0;
            lamp_tie   <= 1'b0;
            score_l    <= '0;
            score_r    <= '0;
            ties       <= '0;
            match_done <= 1'b0;
            winner_r   <= 1'b0;
        end else if (new_match) begin
            state      <= ST_CLEAR;
            clr        <= 1'b1;
            lamp_l     <= 1'b0;
            lamp_r     <= 1'b0;
            lamp_tie   <= 1'b0;
            score_l    <= '0;
            score_r    <= '0;
            ties       <= '0;
            match_done <= 1'b0;
            winner_r   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    clr <= 1'b1;
                end
                ST_ARMED: begin
                    if (winrnd) begin
                        state <= ST_HOLD;
                        if (tie) begin
                            lamp_tie <= 1'b1;
                            if (ties != '1) ties <= ties + SCORE_W'(1);
                        end else if (right) begin
                            lamp_r  <= 1'b1;
                            score_r <= score_r + SCORE_W'(1);
                        end else begin
                            lamp_l  <= 1'b1;
                            score_l <= score_l + SCORE_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (t_done) begin
                        lamp_l   <= 1'b0;
                        lamp_r   <= 1'b0;
                        lamp_tie <= 1'b0;
                        clr      <= 1'b1;
                        if (win_reached) begin
                            state      <= ST_DONE;
                            match_done <= 1'b1;
                            winner_r   <= (score_r == WIN_VAL);
                        end else begin
                            state <= ST_CLEAR;
                        end
                    end
                end
                ST_CLEAR: begin
                    if (t_done) begin
                        state <= ST_ARMED;
                        clr   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    clr <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    clr   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_scorekeeper.sv
// Directed bench for round_scorekeeper with short hold/clear timing.
module tb_round_scorekeeper;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       new_match, winrnd, right, tie;
    logic       clr, lamp_l, lamp_r, lamp_tie, match_done, winner_r;
    logic [3:0] score_l, score_r, ties;

    int total = 0;
    int bad   = 0;
    int exp_l = 0, exp_r = 0, exp_t = 0;

    always #5 clk = ~clk;

    round_scorekeeper #(
        .SCORE_W(4), .WIN_SCORE(3), .HOLD_CYCLES(4), .CLR_CYCLES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .new_match(new_match), .winrnd(winrnd),
        .right(right), .tie(tie), .clr(clr), .lamp_l(lamp_l), .lamp_r(lamp_r),
        .lamp_tie(lamp_tie), .score_l(score_l), .score_r(score_r), .ties(ties),
        .match_done(match_done), .winner_r(winner_r)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_scores(input string tag);
        check({tag, " score_l"}, 32'(score_l), 32'(exp_l));
        check({tag, " score_r"}, 32'(score_r), 32'(exp_r));
        check({tag, " ties"},    32'(ties),    32'(exp_t));
    endtask

    // Plays one round starting at a negedge with the FSM in ARMED.
    task automatic play_round(input string tag, input logic r, input logic t, input logic last);
        winrnd = 1'b1; right = r; tie = t;
        @(negedge clk);
        winrnd = 1'b0; right = 1'b0; tie = 1'b0;
        if (t) exp_t++; else if (r) exp_r++; else exp_l++;
        check_scores(tag);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            check({tag, " lamp_l"},   32'(lamp_l),   32'(!t && !r));
            check({tag, " lamp_r"},   32'(lamp_r),   32'(!t && r));
            check({tag, " lamp_tie"}, 32'(lamp_tie), 32'(t));
            check({tag, " clr hold"}, 32'(clr), 32'(0));
        end
        @(negedge clk);
        check({tag, " lamps off"}, 32'({lamp_l, lamp_r, lamp_tie}), 32'(0));
        check({tag, " clr 1st"}, 32'(clr), 32'(1));
        @(negedge clk);
        check({tag, " clr 2nd"}, 32'(clr), 32'(1));
        check({tag, " match_done"}, 32'(match_done), 32'(last));
        if (!last) begin
            @(negedge clk);
            check({tag, " rearmed clr"}, 32'(clr), 32'(0));
        end
    endtask

    initial begin
        rst_n = 1'b0; new_match = 1'b0; winrnd = 1'b0; right = 1'b0; tie = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset clr", 32'(clr), 32'(1));
        check("reset lamps", 32'({lamp_l, lamp_r, lamp_tie}), 32'(0));
        check("reset match_done", 32'(match_done), 32'(0));
        check("reset winner_r", 32'(winner_r), 32'(0));
        check_scores("reset");
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle clr", 32'(clr), 32'(1));

        // start match: CLEAR for two cycles, then ARMED
        new_match = 1'b1;
        @(negedge clk);
        new_match = 1'b0;
        check("start clr 1st", 32'(clr), 32'(1));
        check_scores("start");
        @(negedge clk);
        check("start clr 2nd", 32'(clr), 32'(1));
        @(negedge clk);
        check("start armed clr", 32'(clr), 32'(0));

        play_round("right win", 1'b1, 1'b0, 1'b0);
        play_round("tie over right", 1'b1, 1'b1, 1'b0);
        play_round("left 1", 1'b0, 1'b0, 1'b0);
        play_round("left 2", 1'b0, 1'b0, 1'b0);
        play_round("left 3", 1'b0, 1'b0, 1'b1);
        check("done winner_r", 32'(winner_r), 32'(0));
        check("done score_l", 32'(score_l), 32'(3));

        // winrnd in DONE changes nothing
        winrnd = 1'b1; right = 1'b1;
        @(negedge clk);
        @(negedge clk);
        winrnd = 1'b0; right = 1'b0;
        check_scores("done frozen");
        check("done frozen lamps", 32'({lamp_l, lamp_r, lamp_tie}), 32'(0));
        check("done frozen clr", 32'(clr), 32'(1));
        check("done frozen match_done", 32'(match_done), 32'(1));

        // new match from DONE
        new_match = 1'b1;
        @(negedge clk);
        new_match = 1'b0;
        exp_l = 0; exp_r = 0; exp_t = 0;
        check_scores("rematch");
        check("rematch match_done", 32'(match_done), 32'(0));
        check("rematch clr", 32'(clr), 32'(1));
        @(negedge clk);
        @(negedge clk);
        check("rematch armed clr", 32'(clr), 32'(0));

        // new_match wins over winrnd in the same ARMED cycle
        new_match = 1'b1; winrnd = 1'b1; right = 1'b1;
        @(negedge clk);
        new_match = 1'b0; winrnd = 1'b0; right = 1'b0;
        check_scores("nm vs win");
        check("nm vs win lamps", 32'({lamp_l, lamp_r, lamp_tie}), 32'(0));
        check("nm vs win clr 1st", 32'(clr), 32'(1));
        @(negedge clk);
        check("nm vs win clr 2nd", 32'(clr), 32'(1));
        @(negedge clk);
        check("nm vs win armed clr", 32'(clr), 32'(0));
        check_scores("nm vs win later");

        // async reset in HOLD with score_r=2
        play_round("right a", 1'b1, 1'b0, 1'b0);
        winrnd = 1'b1; right = 1'b1;
        @(negedge clk);
        winrnd = 1'b0; right = 1'b0;
        check("pre-reset score_r", 32'(score_r), 32'(2));
        check("pre-reset lamp_r", 32'(lamp_r), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        exp_l = 0; exp_r = 0; exp_t = 0;
        check("async clr", 32'(clr), 32'(1));
        check("async lamps", 32'({lamp_l, lamp_r, lamp_tie}), 32'(0));
        check_scores("async");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) @(negedge clk);
        check("post-reset idle clr", 32'(clr), 32'(1));
        check("post-reset lamps", 32'({lamp_l, lamp_r, lamp_tie}), 32'(0));
        check_scores("post-reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
